dmem_responder: RTL and testbench

//   Responder side of the CPU data-memory port. It accepts load and store requests

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, answered LATENCY edges after accept.
// Optional DMEM_ERR_CHECK_EN macro enables size/alignment/range fault reporting on rsp_err.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the sender holds its payload stable while valid is high and ready is low.

  localparam int MEM_BYTES = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [63:0] lat_addr;
  logic [3:0]  lat_size;
  logic [63:0] lat_wdata;

  logic [7:0]  mem [MEM_BYTES];

  logic              size_legal;
  logic [3:0]        eff_size;
  logic [ADDR_W-1:0] eff_addr;
  logic              acc_err;
  logic [63:0]       rd_data;

  assign dbg_state = state;

  always_comb begin
    size_legal = (lat_size == 4'd1) || (lat_size == 4'd2) ||
                 (lat_size == 4'd4) || (lat_size == 4'd8);
`ifdef DMEM_ERR_CHECK_EN
    eff_size = lat_size;
    eff_addr = lat_addr[ADDR_W-1:0];
    acc_err  = !size_legal ||
               ((lat_addr[3:0] & (lat_size - 4'd1)) != 4'd0) ||
               (({1'b0, lat_addr} + 65'(lat_size) - 65'd1) >= 65'(MEM_BYTES));
`else
    // Illegal sizes become 8 and the address is aligned down, so no access can fault.
    eff_size = size_legal ? lat_size : 4'd8;
    eff_addr = lat_addr[ADDR_W-1:0] & ~ADDR_W'(eff_size - 4'd1);
    acc_err  = 1'b0;
`endif
  end

`ifndef DMEM_ERR_CHECK_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^lat_addr[63:ADDR_W];
`endif

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < eff_size) rd_data[8*k +: 8] = mem[eff_addr + ADDR_W'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && lat_write && !acc_err) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < eff_size) mem[eff_addr + ADDR_W'(k)] <= lat_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_size  <= req_size;
            lat_wdata <= req_wdata;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= (LATENCY == 1) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ACCESS;
        end
        ACCESS: begin
          rsp_err   <= acc_err;
          rsp_rdata <= (lat_write || acc_err) ? 64'd0 : rd_data;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (ADDR_W=10, LATENCY=2) with a byte-array reference model.
module tb_dmem_responder;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;
  localparam int MEM    = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [3:0]  req_size = 4'd8;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem_m [MEM];
  logic [63:0] exp_q[$];
  logic        err_q[$];

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: applies the transaction to mem_m and returns the expected response.
  function automatic void model(input logic w, input logic [63:0] a, input logic [3:0] sz,
                                input logic [63:0] wd, output logic [63:0] rd, output logic er);
    longint unsigned n, base;
    logic legal;
    rd = '0;
    er = 1'b0;
    n = longint'(sz);
    legal = (sz == 4'd1) || (sz == 4'd2) || (sz == 4'd4) || (sz == 4'd8);
`ifdef DMEM_ERR_CHECK_EN
    if (!legal) er = 1'b1;
    else if (a % n != 0) er = 1'b1;
    else if (a >= longint'(MEM) || a + n > longint'(MEM)) er = 1'b1;
    base = a;
`else
    if (!legal) n = 8;
    base = (a % longint'(MEM)) / n * n;
`endif
    if (er) return;
    for (int k = 0; k < int'(n); k++) begin
      if (w) mem_m[int'(base) + k] = wd[8*k +: 8];
      else rd[8*k +: 8] = mem_m[int'(base) + k];
    end
  endfunction

  // Drives one request, waits for the response, returns data/err and edges from accept to rsp_valid.
  task automatic do_txn(input logic w, input logic [63:0] a, input logic [3:0] sz,
                        input logic [63:0] wd, output logic [63:0] rd, output logic er,
                        output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    rd = 'x; er = 1'bx; lat = -1;
    if (guard >= 50) return;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        rd = rsp_rdata; er = rsp_err; lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    total++; if (rsp_rdata !== 64'd0) begin bad++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d expected idle(0)", dbg_state); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_fill;
    logic [63:0] rd, erd, wd;
    logic er, eer;
    int lat;
    for (int i = 0; i < 32; i++) begin
      wd = {$urandom, $urandom};
      model(1'b1, 64'(i * 8), 4'd8, wd, erd, eer);
      do_txn(1'b1, 64'(i * 8), 4'd8, wd, rd, er, lat);
      total++; if (er !== 1'b0 || rd !== 64'd0) begin bad++; $display("FAIL fill_store: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
    end
  endtask

  task automatic test_basic;
    logic [63:0] rd, erd;
    logic er, eer;
    int lat;
    model(1'b1, 64'h10, 4'd8, 64'h0123456789ABCDEF, erd, eer);
    do_txn(1'b1, 64'h10, 4'd8, 64'h0123456789ABCDEF, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL basic_store_err: got %b expected 0", er); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL basic_store_latency: got %0d expected %0d", lat, LAT); end
    do_txn(1'b0, 64'h10, 4'd8, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL basic_load_rdata: got %h expected 0123456789abcdef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL basic_load_err: got %b expected 0", er); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL basic_load_latency: got %0d expected %0d", lat, LAT); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_rsp_pulse: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_partial;
    logic [63:0] rd, erd;
    logic er, eer;
    int lat;
    model(1'b1, 64'h13, 4'd1, 64'hAA, erd, eer);
    do_txn(1'b1, 64'h13, 4'd1, 64'hAA, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL partial_store_err: got %b expected 0", er); end
    do_txn(1'b0, 64'h10, 4'd8, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h01234567AAABCDEF) begin bad++; $display("FAIL partial_load8: got %h expected 01234567aaabcdef", rd); end
    do_txn(1'b0, 64'h12, 4'd2, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h000000000000AAAB) begin bad++; $display("FAIL partial_load2: got %h expected 000000000000aaab", rd); end
  endtask

  task automatic test_backpressure;
    logic [63:0] rd0, erd0, erd1;
    logic er0, eer0, eer1;
    int guard;
    bit seen;
    model(1'b0, 64'h10, 4'd8, 64'h0, erd0, eer0);
    model(1'b0, 64'h12, 4'd2, 64'h0, erd1, eer1);
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_size = 4'd8; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0; rd0 = 'x; er0 = 1'bx;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin seen = 1; rd0 = rsp_rdata; er0 = rsp_err; end
    end
    total++; if (!seen || rd0 !== erd0 || er0 !== eer0) begin bad++; $display("FAIL bp_first_rsp: got valid=%b rdata=%h err=%b expected valid=1 rdata=%h err=%b", seen, rd0, er0, erd0, eer0); end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h12; req_size = 4'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== erd0 || rsp_err !== eer0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: got valid=%b rdata=%h err=%b req_ready=%b expected valid=1 rdata=%h err=%b req_ready=0",
                 rsp_valid, rsp_rdata, rsp_err, req_ready, erd0, eer0);
      end
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_after_handshake: got valid=%b req_ready=%b expected valid=0 req_ready=1", rsp_valid, req_ready); end
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept: got req_ready=%b expected 0", req_ready); end
    req_valid = 1'b0;
    seen = 0;
    for (int i = 1; i <= 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        seen = 1;
        total++; if (i !== LAT || rsp_rdata !== erd1) begin bad++; $display("FAIL bp_second_rsp: got lat=%0d rdata=%h expected lat=%0d rdata=%h", i, rsp_rdata, LAT, erd1); end
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL bp_second_timeout: got no response expected response"); end
  endtask

`ifdef DMEM_ERR_CHECK_EN
  task automatic test_errors;
    logic [63:0] rd, erd;
    logic er, eer;
    int lat;
    model(1'b1, 64'h12, 4'd4, 64'hDEADBEEF, erd, eer);
    do_txn(1'b1, 64'h12, 4'd4, 64'hDEADBEEF, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_misaligned_store: got %b expected 1", er); end
    model(1'b0, 64'h10, 4'd8, 64'h0, erd, eer);
    do_txn(1'b0, 64'h10, 4'd8, 64'h0, rd, er, lat);
    total++; if (rd !== erd || er !== 1'b0) begin bad++; $display("FAIL err_bytes_unchanged: got %h err=%b expected %h err=0", rd, er, erd); end
    do_txn(1'b0, 64'h400, 4'd8, 64'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 64'd0) begin bad++; $display("FAIL err_out_of_range: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    do_txn(1'b0, 64'h10, 4'd3, 64'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 64'd0) begin bad++; $display("FAIL err_bad_size: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
  endtask
`else
  task automatic test_no_err;
    logic [63:0] rd, erd;
    logic er, eer;
    int lat;
    model(1'b1, 64'h12, 4'd4, 64'hDEADBEEF, erd, eer);
    do_txn(1'b1, 64'h12, 4'd4, 64'hDEADBEEF, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL noerr_store_err: got %b expected 0", er); end
    do_txn(1'b0, 64'h10, 4'd4, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h00000000DEADBEEF) begin bad++; $display("FAIL noerr_aligned_load: got %h expected 00000000deadbeef", rd); end
    model(1'b0, 64'h10, 4'd8, 64'h0, erd, eer);
    do_txn(1'b0, 64'h410, 4'd8, 64'h0, rd, er, lat);
    total++; if (rd !== erd || er !== 1'b0) begin bad++; $display("FAIL noerr_wrap_load: got %h err=%b expected %h err=0", rd, er, erd); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [63:0] rd, erd;
    logic er, eer;
    int lat, guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_size = 4'd8; req_wdata = '1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL midreset_outputs: got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_rsp: got %b expected 0", rsp_valid); end
    model(1'b0, 64'h20, 4'd8, 64'h0, erd, eer);
    do_txn(1'b0, 64'h20, 4'd8, 64'h0, rd, er, lat);
    total++; if (rd !== erd) begin bad++; $display("FAIL midreset_mem_kept: got %h expected %h", rd, erd); end
  endtask

  task automatic test_random;
    logic [63:0] rd, erd, wd, a, exp_rd;
    logic er, eer, exp_er, w;
    logic [3:0] sz;
    int lat, pick;
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 9);
      sz = (pick < 2) ? 4'd1 : (pick < 4) ? 4'd2 : (pick < 6) ? 4'd4 : (pick < 8) ? 4'd8 :
           (pick == 8) ? 4'd3 : 4'd6;
      a = 64'($urandom_range(0, 255));
`ifdef DMEM_ERR_CHECK_EN
      if ($urandom_range(0, 7) == 0) a = a + 64'h400;
`else
      a = a + 64'(MEM * $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a[40] = 1'b1;
`endif
      w = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      model(w, a, sz, wd, erd, eer);
      exp_q.push_back(erd);
      err_q.push_back(eer);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(w, a, sz, wd, rd, er, lat);
      exp_rd = exp_q.pop_front();
      exp_er = err_q.pop_front();
      total++;
      if (rd !== exp_rd || er !== exp_er || lat !== LAT) begin
        bad++;
        $display("FAIL random_txn[%0d] w=%b a=%h sz=%0d: got rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=%0d",
                 i, w, a, sz, rd, er, lat, exp_rd, exp_er, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_partial();
    test_backpressure();
`ifdef DMEM_ERR_CHECK_EN
    test_errors();
`else
    test_no_err();
`endif
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
